// File: rtl/baud_tick_gen_if.sv
// Baud tick generator bus: control strobes in, tick pulses and active divisor out.
interface baud_tick_gen_if #(
  parameter int unsigned DIV_W = 16
) ();
  logic             en;
  logic [DIV_W-1:0] div_value;
  logic             div_load;
  logic             resync;
  logic             sample_tick;
  logic             mid_tick;
  logic             bit_tick;
  logic             sample_clk;
  logic [DIV_W-1:0] div_active;

  // Controller side drives the strobes and observes the ticks
  modport master (
    output en, div_value, div_load, resync,
    input  sample_tick, mid_tick, bit_tick, sample_clk, div_active
  );

  // Generator side
  modport slave (
    input  en, div_value, div_load, resync,
    output sample_tick, mid_tick, bit_tick, sample_clk, div_active
  );
endinterface

// File: rtl/baud_tick_gen.sv
// Programmable baud tick generator: divides clk into oversampling ticks, then
// derives bit-centre and bit-end pulses from an OSR-deep oversample counter.
module baud_tick_gen #(
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned OSR       = 16,
  parameter int unsigned DIV_RESET = 15
) (
  input logic            clk,
  input logic            rst_n,
  baud_tick_gen_if.slave bus
);
  localparam int unsigned      OS_W    = $clog2(OSR);
  localparam logic [OS_W-1:0]  OS_MID  = OS_W'(OSR / 2 - 1);
  localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OSR - 1);
  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_RESET);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0] div_active_q, div_active_d;
  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
  logic             sample_tick_q, sample_tick_d;
  logic             mid_tick_q, mid_tick_d;
  logic             bit_tick_q, bit_tick_d;
  logic             sample_clk_q, sample_clk_d;
  logic [DIV_W-1:0] div_last_c;

  // Terminal count of the divider; a zero divisor behaves as one
  always_comb begin
    div_last_c = (div_active_q == '0) ? '0 : div_active_q - DIV_W'(1);
  end

  // Next-state: en low and resync clear the phase, otherwise count and tick on wrap
  always_comb begin
    div_cnt_d     = div_cnt_q;
    div_active_d  = div_active_q;
    shadow_d      = shadow_q;
    pend_d        = pend_q;
    os_cnt_d      = os_cnt_q;
    sample_tick_d = 1'b0;
    mid_tick_d    = 1'b0;
    bit_tick_d    = 1'b0;
    sample_clk_d  = sample_clk_q;

    if (!bus.en || bus.resync) begin
      // Phase restart; a load here applies at once since no period is in flight
      div_cnt_d = '0;
      os_cnt_d  = '0;
      if (bus.div_load) begin
        div_active_d = bus.div_value;
        shadow_d     = bus.div_value;
        pend_d       = 1'b0;
      end
    end else begin
      if (bus.div_load) begin
        shadow_d = bus.div_value;
        pend_d   = 1'b1;
      end
      if (div_cnt_q == div_last_c) begin
        div_cnt_d     = '0;
        sample_tick_d = 1'b1;
        sample_clk_d  = ~sample_clk_q;
        mid_tick_d    = (os_cnt_q == OS_MID);
        bit_tick_d    = (os_cnt_q == OS_LAST);
        os_cnt_d      = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OS_W'(1);
        // Pending divisor switches in on the wrap so the old period completes
        if (pend_q || bus.div_load) begin
          div_active_d = bus.div_load ? bus.div_value : shadow_q;
          pend_d       = 1'b0;
        end
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q     <= '0;
      div_active_q  <= DIV_RST;
      shadow_q      <= DIV_RST;
      pend_q        <= 1'b0;
      os_cnt_q      <= '0;
      sample_tick_q <= 1'b0;
      mid_tick_q    <= 1'b0;
      bit_tick_q    <= 1'b0;
      sample_clk_q  <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      div_active_q  <= div_active_d;
      shadow_q      <= shadow_d;
      pend_q        <= pend_d;
      os_cnt_q      <= os_cnt_d;
      sample_tick_q <= sample_tick_d;
      mid_tick_q    <= mid_tick_d;
      bit_tick_q    <= bit_tick_d;
      sample_clk_q  <= sample_clk_d;
    end
  end

  assign bus.sample_tick = sample_tick_q;
  assign bus.mid_tick    = mid_tick_q;
  assign bus.bit_tick    = bit_tick_q;
  assign bus.sample_clk  = sample_clk_q;
  assign bus.div_active  = div_active_q;
endmodule
